// File: rtl/dram_pattern_tester.sv
// SDRAM pattern tester: writes a selectable pattern over an address window, reads it back,
// compares every word, and reports errors, first failing address, passes and timeouts.
module dram_pattern_tester #(
    parameter int unsigned                DATA_WIDTH = 16,
    parameter int unsigned                ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0]      ADDR_LAST  = 24'hFFFFFF,
    parameter int unsigned                ERR_WIDTH  = 16,
    parameter int unsigned                LED_WIDTH  = 8,
    parameter int unsigned                TIMEOUT    = 1023,
    parameter logic [DATA_WIDTH-1:0]      LFSR_SEED  = 16'hACE1,
    parameter logic [DATA_WIDTH-1:0]      LFSR_TAPS  = 16'hB400
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            mode_i,
    input  logic                  busy_i,
    input  logic                  rd_ready_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  rd_enable_o,
    output logic                  wr_enable_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ERR_WIDTH-1:0]  err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [7:0]            pass_count_o,
    output logic                  done_o,
    output logic [LED_WIDTH-1:0]  leds_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_PASS_END, S_DONE
    } state_t;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned MW = ADDR_WIDTH + 32;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
    logic [DATA_WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [ERR_WIDTH-1:0]    err_q, err_d;
    logic [7:0]              pass_q, pass_d;
    logic [3:0]              mode_q, mode_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    tmo_flag_q, tmo_flag_d;
    logic                    err_seen_q, err_seen_d;
    logic                    pass_done_q, pass_done_d;
    logic [LED_WIDTH-1:0]    leds_q, leds_d;

    logic [DATA_WIDTH-1:0]            pattern, lfsr_next;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] addr_ext;
    logic [MW-1:0]                    walk_idx;
    logic                             addr_last, in_hs, tmo_hit, mismatch;

    // Expected word for the current address; shared by the write and the compare paths.
    always_comb begin
        addr_ext  = {{DATA_WIDTH{1'b0}}, addr_q};
        walk_idx  = MW'(addr_q) % MW'(DATA_WIDTH);
        lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        case (mode_q[1:0])
            2'd0:    pattern = addr_ext[DATA_WIDTH-1:0];
            2'd1:    pattern = DATA_WIDTH'(1) << walk_idx;
            2'd2:    pattern = {(DATA_WIDTH/2){2'b10}} ^ {DATA_WIDTH{addr_q[0]}};
            default: pattern = lfsr_q;
        endcase
        addr_last = (addr_q == ADDR_LAST);
        mismatch  = (rd_data_q != pattern);
        in_hs     = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT) ||
                    (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
        tmo_hit   = in_hs && (tmo_q == TW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        first_err_d = first_err_q;
        lfsr_d      = lfsr_q;
        rd_data_d   = rd_data_q;
        err_d       = err_q;
        pass_d      = pass_q;
        mode_d      = mode_q;
        tmo_d       = in_hs ? tmo_q + TW'(1) : tmo_q;
        tmo_flag_d  = tmo_flag_q;
        err_seen_d  = err_seen_q;
        pass_done_d = pass_done_q;

        case (state_q)
            S_IDLE: begin
                mode_d  = mode_i;
                addr_d  = '0;
                lfsr_d  = LFSR_SEED;
                state_d = S_WR_REQ;
            end
            S_WR_REQ:  if (busy_i) state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (!busy_i) begin
                    if (addr_last) begin
                        state_d = S_RD_REQ;
                        addr_d  = '0;
                        lfsr_d  = LFSR_SEED;
                    end else begin
                        state_d = S_WR_REQ;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        lfsr_d  = lfsr_next;
                    end
                end
            end
            S_RD_REQ:  if (busy_i) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rd_ready_i) begin
                    rd_data_d = rd_data_i;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                lfsr_d = lfsr_next;
                if (mismatch) begin
                    err_d = (&err_q) ? err_q : err_q + ERR_WIDTH'(1);
                    if (!err_seen_q) begin
                        first_err_d = addr_q;
                        err_seen_d  = 1'b1;
                    end
                end
                if (mismatch && mode_q[3]) begin
                    state_d = S_DONE;
                end else if (addr_last) begin
                    state_d = S_PASS_END;
                end else begin
                    state_d = S_RD_REQ;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_PASS_END: begin
                pass_d      = pass_q + 8'd1;
                pass_done_d = 1'b1;
                state_d     = mode_q[2] ? S_IDLE : S_DONE;
            end
            default: state_d = S_DONE;
        endcase

        // A stalled controller overrides whatever handshake progress was computed above.
        if (tmo_hit) begin
            state_d    = S_DONE;
            tmo_flag_d = 1'b1;
        end
        if ((state_d == S_WR_REQ || state_d == S_RD_REQ) && state_d != state_q) tmo_d = '0;

        leds_d    = LED_WIDTH'(err_d) << 4;
        leds_d[0] = (state_d != S_DONE);
        leds_d[1] = pass_done_d && (err_d == '0);
        leds_d[2] = (err_d != '0);
        leds_d[3] = tmo_flag_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            first_err_q <= '0;
            lfsr_q      <= LFSR_SEED;
            rd_data_q   <= '0;
            err_q       <= '0;
            pass_q      <= '0;
            mode_q      <= '0;
            tmo_q       <= '0;
            tmo_flag_q  <= 1'b0;
            err_seen_q  <= 1'b0;
            pass_done_q <= 1'b0;
            leds_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            first_err_q <= first_err_d;
            lfsr_q      <= lfsr_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
            mode_q      <= mode_d;
            tmo_q       <= tmo_d;
            tmo_flag_q  <= tmo_flag_d;
            err_seen_q  <= err_seen_d;
            pass_done_q <= pass_done_d;
            leds_q      <= leds_d;
        end
    end

    assign wr_enable_o      = (state_q == S_WR_REQ);
    assign rd_enable_o      = (state_q == S_RD_REQ);
    assign wr_data_o        = wr_enable_o ? pattern : '0;
    assign addr_o           = addr_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_err_q;
    assign pass_count_o     = pass_q;
    assign done_o           = (state_q == S_DONE);
    assign leds_o           = leds_q;

endmodule

// File: tb/tb_dram_pattern_tester.sv
// Bench for dram_pattern_tester: a modelled SDRAM controller plus a transaction-level
// reference that predicts every request and the final status registers.
`timescale 1ns/1ps
module tb_dram_pattern_tester;
    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int LAST = 15;
    localparam int EW   = 16;
    localparam int LW   = 8;
    localparam int TMO  = 20;
    localparam logic [DW-1:0] SEED = 16'hACE1;
    localparam logic [DW-1:0] TAPS = 16'hB400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    mode_i = 4'd0;
    logic          busy_i = 1'b0;
    logic          rd_ready_i = 1'b0;
    logic [DW-1:0] rd_data_i = '0;
    logic          rd_enable_o, wr_enable_o, done_o;
    logic [DW-1:0] wr_data_o;
    logic [AW-1:0] addr_o, first_err_addr_o;
    logic [EW-1:0] err_count_o;
    logic [7:0]    pass_count_o;
    logic [LW-1:0] leds_o;

    always #5 clk = ~clk;

    dram_pattern_tester #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_LAST(8'(LAST)), .ERR_WIDTH(EW),
        .LED_WIDTH(LW), .TIMEOUT(TMO), .LFSR_SEED(SEED), .LFSR_TAPS(TAPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .busy_i(busy_i),
        .rd_ready_i(rd_ready_i), .rd_data_i(rd_data_i), .rd_enable_o(rd_enable_o),
        .wr_enable_o(wr_enable_o), .wr_data_o(wr_data_o), .addr_o(addr_o),
        .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
        .pass_count_o(pass_count_o), .done_o(done_o), .leds_o(leds_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // scenario configuration
    logic [3:0]    pass_mode = 4'd0;
    bit            ctrl_dead = 0;
    bit            corrupt_en = 0;
    int            corrupt_addr = 0;
    logic [DW-1:0] corrupt_val = '0;

    // reference model / controller state
    logic [DW-1:0] mem [0:LAST];
    int m_err, m_pass, m_first, m_phase, m_addr;
    bit m_seen, m_stop, m_passed;
    int n_wr, n_rd, last_rd_addr, wr_run, wr_run_max;
    bit prev_wr, prev_rd;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;
    int bcnt, rcnt, rd_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lfsr_at(input int n);
        logic [DW-1:0] v = SEED;
        for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
        return v;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [3:0] m, input int a);
        case (m[1:0])
            2'd0:    return DW'(a);
            2'd1:    return DW'(1) << (a % DW);
            2'd2:    return (a % 2 == 0) ? 16'hAAAA : 16'h5555;
            default: return lfsr_at(a);
        endcase
    endfunction

    task automatic chk_status(input string tag);
        chk({tag, "_err"},   32'(err_count_o), m_err);
        chk({tag, "_first"}, 32'(first_err_addr_o), m_seen ? m_first : 0);
        chk({tag, "_pass"},  32'(pass_count_o), m_pass % 256);
        chk({tag, "_done"},  32'(done_o), 0);
        chk({tag, "_run"},   32'(leds_o[0]), 1);
    endtask

    // Single engine: checks each new request against the model, then plays the controller.
    initial begin : engine
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_i = 0; rd_ready_i = 0; bcnt = 0; rcnt = 0; rd_addr = 0;
                m_err = 0; m_pass = 0; m_first = 0; m_seen = 0; m_stop = 0; m_passed = 0;
                m_phase = 0; m_addr = 0; n_wr = 0; n_rd = 0; last_rd_addr = -1;
                prev_wr = 0; prev_rd = 0; wr_run = 0; wr_run_max = 0;
            end else begin
                chk("both_en", 32'(wr_enable_o & rd_enable_o), 0);
                wr_run = wr_enable_o ? wr_run + 1 : 0;
                if (wr_run > wr_run_max) wr_run_max = wr_run;
                if (wr_enable_o && !prev_wr) begin
                    chk("wr_phase", m_phase, 0);
                    chk("wr_addr", 32'(addr_o), m_addr);
                    chk("wr_data", 32'(wr_data_o), 32'(pat(pass_mode, m_addr)));
                    chk_status("wr");
                    if (pass_mode[1:0] == 2'd3 && m_addr == 1) chk("pin_lfsr1", 32'(wr_data_o), 32'hE270);
                    if (pass_mode[1:0] == 2'd3 && m_addr == 3) chk("pin_lfsr3", 32'(wr_data_o), 32'h389C);
                    if (pass_mode[1:0] == 2'd2 && m_addr == 5) chk("pin_chk5", 32'(wr_data_o), 32'h5555);
                    if (pass_mode[1:0] == 2'd2 && m_addr == 0) chk("pin_chk0", 32'(wr_data_o), 32'hAAAA);
                    if (pass_mode[1:0] == 2'd1 && m_addr == 5) chk("pin_walk5", 32'(wr_data_o), 32'h0020);
                    if (pass_mode[1:0] == 2'd0 && m_addr == 9) chk("pin_addr9", 32'(wr_data_o), 32'h0009);
                    n_wr++; held_addr = addr_o; held_data = wr_data_o;
                    m_addr++;
                    if (m_addr > LAST) begin m_addr = 0; m_phase = 1; end
                end else if (wr_enable_o) begin
                    chk("wr_hold_addr", 32'(addr_o), 32'(held_addr));
                    chk("wr_hold_data", 32'(wr_data_o), 32'(held_data));
                end
                if (rd_enable_o && !prev_rd) begin
                    chk("rd_phase", m_phase, 1);
                    chk("rd_addr", 32'(addr_o), m_addr);
                    chk_status("rd");
                    n_rd++; last_rd_addr = int'(addr_o);
                    m_addr++;
                    if (m_addr > LAST) begin m_addr = 0; m_phase = 0; end
                end
                prev_wr = wr_enable_o;
                prev_rd = rd_enable_o;

                rd_ready_i = 0;
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        d = mem[rd_addr];
                        if (corrupt_en && rd_addr == corrupt_addr) d = corrupt_val;
                        rd_data_i = d; rd_ready_i = 1;
                        if (d != pat(pass_mode, rd_addr)) begin
                            m_err++;
                            if (!m_seen) begin m_seen = 1; m_first = rd_addr; end
                            if (pass_mode[3]) m_stop = 1;
                        end
                        if (rd_addr == LAST && !m_stop) begin m_pass++; m_passed = 1; end
                    end
                end
                if (bcnt > 0) begin
                    bcnt--;
                    busy_i = (bcnt > 0);
                end else if (!ctrl_dead && (wr_enable_o || rd_enable_o)) begin
                    busy_i = 1; bcnt = 3;
                    if (wr_enable_o) mem[int'(addr_o)] = wr_data_o;
                    else begin rcnt = 5; rd_addr = int'(addr_o); end
                end
            end
        end
    end

    task automatic start(input logic [3:0] m, input bit dead, input bit cen, input int ca);
        rst_n = 0; mode_i = m; pass_mode = m; ctrl_dead = dead;
        corrupt_en = cen; corrupt_addr = ca; corrupt_val = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while (!done_o && c < budget) begin @(negedge clk); c++; end
        chk({name, "_reach_done"}, 32'(done_o), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic fin(input string name, input bit exp_done, input bit tmo);
        logic [7:0] el;
        el = {4'(m_err), tmo, (m_err != 0), (m_passed && m_err == 0), !exp_done};
        chk({name, "_err"},   32'(err_count_o), m_err);
        chk({name, "_first"}, 32'(first_err_addr_o), m_seen ? m_first : 0);
        chk({name, "_pass"},  32'(pass_count_o), m_pass % 256);
        chk({name, "_done"},  32'(done_o), 32'(exp_done));
        chk({name, "_leds"},  32'(leds_o), 32'(el));
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c;
        // 1: address-as-data, single pass; a mid-pass mode change must be ignored
        start(4'd0, 0, 0, 0);
        repeat (40) @(negedge clk);
        mode_i = 4'b0110;
        wait_done("s1", 2000);
        fin("s1", 1, 0);
        chk("s1_nwr", n_wr, 16);
        chk("s1_nrd", n_rd, 16);
        chk("s1_err_lit", 32'(err_count_o), 0);
        chk("s1_pass_lit", 32'(pass_count_o), 1);
        chk("s1_led1", 32'(leds_o[1]), 1);

        // 2: checkerboard, read of address 5 corrupted
        start(4'd2, 0, 1, 5);
        wait_done("s2", 2000);
        fin("s2", 1, 0);
        chk("s2_err_lit", 32'(err_count_o), 1);
        chk("s2_first_lit", 32'(first_err_addr_o), 5);
        chk("s2_led2", 32'(leds_o[2]), 1);
        chk("s2_nrd", n_rd, 16);

        // 3: LFSR with stop-on-error, address 3 corrupted
        start(4'b1011, 0, 1, 3);
        wait_done("s3", 2000);
        fin("s3", 1, 0);
        chk("s3_err_lit", 32'(err_count_o), 1);
        chk("s3_nrd", n_rd, 4);
        chk("s3_last_rd", last_rd_addr, 3);
        chk("s3_pass_lit", 32'(pass_count_o), 0);

        // 4: walking one, continuous, address 2 corrupted every pass
        start(4'b0101, 0, 1, 2);
        c = 0;
        while (pass_count_o != 8'd3 && c < 3000) begin @(negedge clk); c++; end
        chk("s4_pass_lit", 32'(pass_count_o), 3);
        chk("s4_err_lit", 32'(err_count_o), 3);
        chk("s4_first_lit", 32'(first_err_addr_o), 2);
        fin("s4", 0, 0);

        // 5: controller never accepts -> timeout
        start(4'd0, 1, 0, 0);
        wait_done("s5", 200);
        chk("s5_en_cycles", wr_run_max, TMO);
        chk("s5_led3", 32'(leds_o[3]), 1);
        fin("s5", 1, 1);

        // 6: asynchronous reset in the middle of the read phase
        start(4'd0, 0, 0, 0);
        c = 0;
        while (!(rd_enable_o && addr_o == 8'd4) && c < 1000) begin @(negedge clk); c++; end
        chk("s6_reach_rd4", 32'(rd_enable_o), 1);
        #2 rst_n = 0;
        #1;
        chk("s6_rst_rd_en", 32'(rd_enable_o), 0);
        chk("s6_rst_wr_en", 32'(wr_enable_o), 0);
        chk("s6_rst_addr", 32'(addr_o), 0);
        chk("s6_rst_wdata", 32'(wr_data_o), 0);
        chk("s6_rst_pass", 32'(pass_count_o), 0);
        chk("s6_rst_done", 32'(done_o), 0);
        chk("s6_rst_leds", 32'(leds_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        c = 0;
        while (!wr_enable_o && c < 20) begin @(negedge clk); c++; end
        chk("s6_restart_wr", 32'(wr_enable_o), 1);
        chk("s6_restart_addr", 32'(addr_o), 0);
        wait_done("s6", 2000);
        fin("s6", 1, 0);
        chk("s6_nwr", n_wr, 16);
        chk("s6_nrd", n_rd, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
